// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipe: load-use stalls, branch flushes and saturating event counters.
// Optional HAZARD_MEMWAIT_EN adds the mem_busy_i freeze and a deferred (PEND) branch flush.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
`ifdef HAZARD_MEMWAIT_EN
    input  logic             mem_busy_i,
`endif
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_sel_o,
    output logic             exmem_flush_o,
    output logic             pipe_hold_o,
    output logic             pc_src_sel_o,
    output logic [31:0]      pc_target_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic bubble;
        logic exmem_flush;
        logic hold;
        logic pc_src;
    } ctrl_t;

    ctrl_t            w_ctrl;
    logic             w_busy;
    logic             w_pend;
    logic             w_lu;
    logic             w_flush;
    logic             w_stall;
    logic [31:0]      w_target;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    assign w_lu = idex_memread_i && (idex_rt_i != 5'd0) &&
                  ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

`ifdef HAZARD_MEMWAIT_EN
    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_capture;
    logic [31:0] r_tgt_q;

    assign w_busy    = mem_busy_i;
    assign w_capture = (r_state == ST_IDLE) && branch_taken_i && w_busy;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A pending branch waits out the freeze; new branches are ignored meanwhile.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_capture) w_state_nxt = ST_PEND;
            ST_PEND: if (!w_busy)   w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)         r_tgt_q <= 32'd0;
        else if (w_capture) r_tgt_q <= branch_target_i;
    end

    assign w_pend   = (r_state == ST_PEND);
    assign w_target = w_pend ? r_tgt_q : branch_target_i;
`else
    assign w_busy   = 1'b0;
    assign w_pend   = 1'b0;
    assign w_target = branch_target_i;
`endif

    // Priority: freeze > flush > load-use > run.
    always_comb begin
        w_ctrl  = '0;
        w_flush = 1'b0;
        w_stall = 1'b0;
        if (w_busy) begin
            w_ctrl.hold = 1'b1;
        end else if (w_pend || branch_taken_i) begin
            w_flush            = 1'b1;
            w_ctrl.pc_write    = 1'b1;
            w_ctrl.pc_src      = 1'b1;
            w_ctrl.ifid_flush  = 1'b1;
            w_ctrl.bubble      = 1'b1;
            w_ctrl.exmem_flush = 1'b1;
        end else if (w_lu) begin
            w_stall       = 1'b1;
            w_ctrl.bubble = 1'b1;
        end else begin
            w_ctrl.pc_write   = 1'b1;
            w_ctrl.ifid_write = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_stall || w_busy) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush && (r_flush_cnt != '1))             r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    // Reset forces every output low, including the combinational controls.
    assign pc_write_o        = rst_i & w_ctrl.pc_write;
    assign ifid_write_o      = rst_i & w_ctrl.ifid_write;
    assign ifid_flush_o      = rst_i & w_ctrl.ifid_flush;
    assign idex_bubble_sel_o = rst_i & w_ctrl.bubble;
    assign exmem_flush_o     = rst_i & w_ctrl.exmem_flush;
    assign pipe_hold_o       = rst_i & w_ctrl.hold;
    assign pc_src_sel_o      = rst_i & w_ctrl.pc_src;
    assign pc_target_o       = rst_i ? w_target : 32'd0;
    assign stall_cnt_o       = r_stall_cnt;
    assign flush_cnt_o       = r_flush_cnt;

endmodule
